// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding, frame layout constants, IMEM data width and small helpers.
package imem_loader_pkg;

  // IMEM word width written over port B.
  localparam int IMEM_DW = 16;

  // Frame layout: two length bytes up front, one checksum byte at the end.
  localparam int HDR_BYTES = 2;
  localparam int CHK_BYTES = 1;

  // Loader FSM states, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_IDLE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  // True in the states that take bytes from the link.
  function automatic logic is_receiving(input state_e st);
    logic r;
    case (st)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Running frame checksum: 8-bit sum that wraps.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_timeout.sv
// Idle-gap watchdog for the loader: counts cycles spent waiting for a byte
// while a frame is in progress and flags when the gap limit is reached.
// A limit of 0 disables the watchdog.
module imem_loader_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,   // frame in progress and a byte is awaited
  input  logic kick,     // a byte was accepted this cycle
  output logic expired   // this cycle is the TIMEOUT_CYCLES-th idle cycle
);

  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt =
    CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic Enabled = (TIMEOUT_CYCLES > 0);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            at_last_s;

  assign at_last_s = (cnt_q == LastCnt);

  // Expiry is flagged in the idle cycle whose edge would reach the limit,
  // so the FSM leaves on exactly that edge.
  assign expired = Enabled & active & ~kick & at_last_s;

  // Next idle count: cleared by a byte or when no frame is in progress.
  always_comb begin
    cnt_d = cnt_q;
    if (!active || kick) begin
      cnt_d = '0;
    end else if (at_last_s) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Idle count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a length-prefixed, checksummed byte frame and
// writes big-endian 16-bit words into IMEM port B from address 0. Keeps the
// CPU halted while loading and pulses cpu_rst once a frame checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W         = 16,
  parameter logic [15:0] MAX_WORDS      = 16'd4096,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               load_req,
  output logic [ADDR_W-1:0]  ADDRB,
  output logic [IMEM_DW-1:0] DINB,
  output logic               WEB,
  output logic               Halt,
  output logic               cpu_rst,
  output logic               done,
  output logic               error
);

  // Elaboration-time sanity checks on the configuration.
  if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
    $error("imem_loader: ADDR_W must be in 1..16");
  end
  if (longint'(MAX_WORDS) > (longint'(1) << ADDR_W)) begin : g_bad_max_words
    $error("imem_loader: MAX_WORDS exceeds the IMEM address space");
  end
  if (HDR_BYTES != 2 || CHK_BYTES != 1) begin : g_bad_frame
    $error("imem_loader: frame layout does not match the FSM byte sequence");
  end

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [IMEM_DW-1:0]  dinb_q, dinb_d;
  logic                web_q, web_d;
  logic                halt_q, halt_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                rx_ready_q, rx_ready_d;

  logic                accept_s;
  logic                active_s;
  logic                expired_s;
  logic [15:0]         len_s;
  logic [15:0]         cnt_inc_s;

  assign accept_s  = rx_valid & rx_ready_q;
  assign len_s     = {len_q[15:8], rx_data};
  assign cnt_inc_s = cnt_q + 16'd1;

  // The idle watchdog runs only once the first length byte is in, so the
  // loader can wait forever for a frame to begin.
  assign active_s = (state_q == ST_LEN_LO) || (state_q == ST_DATA_HI) ||
                    (state_q == ST_DATA_LO) || (state_q == ST_CHECK);

  imem_loader_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (active_s),
    .kick   (accept_s),
    .expired(expired_s)
  );

  // Next-state, datapath and output decode; all outputs are derived from
  // the next state so they are registered alongside it.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    addrb_d = addrb_q;
    dinb_d  = dinb_q;
    web_d   = 1'b0;

    case (state_q)
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d   = {rx_data, 8'd0};
          sum_d   = sum8(sum_q, rx_data);
          state_d = ST_LEN_LO;
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d = len_s;
          sum_d = sum8(sum_q, rx_data);
          if (len_s == 16'd0) begin
            state_d = ST_CHECK;
          end else if (len_s > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_DATA_HI: begin
        if (accept_s) begin
          hi_d    = rx_data;
          sum_d   = sum8(sum_q, rx_data);
          state_d = ST_DATA_LO;
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          sum_d   = sum8(sum_q, rx_data);
          dinb_d  = {hi_q, rx_data};
          addrb_d = cnt_q[ADDR_W-1:0];
          web_d   = 1'b1;
          cnt_d   = cnt_inc_s;
          if (cnt_inc_s == len_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA_LO;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (rx_data == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_IDLE, ST_ERR: begin
        if (load_req) begin
          state_d = ST_LEN_HI;
          cnt_d   = 16'd0;
          sum_d   = 8'd0;
          addrb_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase

    rx_ready_d = is_receiving(state_d);
    done_d     = (state_d == ST_DONE) || (state_d == ST_IDLE);
    halt_d     = ~done_d;
    error_d    = (state_d == ST_ERR);
    cpu_rst_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset starts a boot load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LEN_HI;
      len_q      <= 16'd0;
      hi_q       <= 8'd0;
      cnt_q      <= 16'd0;
      sum_q      <= 8'd0;
      addrb_q    <= '0;
      dinb_q     <= '0;
      web_q      <= 1'b0;
      halt_q     <= 1'b1;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      addrb_q    <= addrb_d;
      dinb_q     <= dinb_d;
      web_q      <= web_d;
      halt_q     <= halt_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign ADDRB    = addrb_q;
  assign DINB     = dinb_q;
  assign WEB      = web_q;
  assign Halt     = halt_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the plan plus
// randomized frames, each predicted by a frame-level reference model.
module tb_imem_loader;

  localparam int          TO   = 10;
  localparam logic [15:0] MAXW = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic [15:0] ADDRB;
  logic [15:0] DINB;
  logic        WEB;
  logic        Halt;
  logic        cpu_rst;
  logic        done;
  logic        error;

  imem_loader #(
    .ADDR_W(16),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .load_req(load_req), .ADDRB(ADDRB), .DINB(DINB),
    .WEB(WEB), .Halt(Halt), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  fb[$];     // frame bytes
  int          fg[$];     // idle cycles before each byte
  logic [31:0] wr_q[$];   // observed writes {addr, data}
  logic [31:0] exp_wr[$]; // predicted writes
  int          rst_cnt;
  bit          exp_ok;

  // Observe IMEM writes and CPU reset pulses away from the active edge.
  always @(negedge clk) begin
    if (WEB === 1'b1) wr_q.push_back({ADDRB, DINB});
    if (cpu_rst === 1'b1) rst_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: works on the whole frame at once from the frame rules.
  task automatic model_frame();
    int n, last, cut, s;
    n    = {fb[0], fb[1]};
    last = (n > int'(MAXW)) ? 1 : 2 + 2 * n;
    cut  = last + 1;
    for (int i = 1; i <= last; i++)
      if (fg[i] >= TO && cut == last + 1) cut = i;
    exp_wr.delete();
    if (n <= int'(MAXW))
      for (int w = 0; w < n; w++)
        if (3 + 2 * w < cut) exp_wr.push_back({16'(w), fb[2 + 2 * w], fb[3 + 2 * w]});
    if (cut <= last || n > int'(MAXW)) begin
      exp_ok = 1'b0;
    end else begin
      s = 0;
      for (int i = 0; i < last; i++) s += int'(fb[i]);
      exp_ok = (8'(s) == fb[last]);
    end
  endtask

  task automatic drive_frame();
    for (int i = 0; i < fb.size(); i++) begin
      rx_valid = 1'b0;
      repeat (fg[i]) step();
      rx_valid = 1'b1;
      rx_data  = fb[i];
      step();
    end
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic run_frame(input string name, input bit need_req);
    wr_q.delete();
    rst_cnt = 0;
    if (need_req) begin
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      check_eq({name, "_req_halt"}, 32'(Halt), 32'd1);
      check_eq({name, "_req_done"}, 32'(done), 32'd0);
      check_eq({name, "_req_err"}, 32'(error), 32'd0);
      check_eq({name, "_req_addr"}, 32'(ADDRB), 32'd0);
    end
    model_frame();
    drive_frame();
    check_eq({name, "_rdy_end"}, 32'(rx_ready), 32'd0);
    repeat (3) step();
    @(negedge clk);
    check_eq({name, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check_eq($sformatf("%s_wr%0d", name, i), wr_q[i], exp_wr[i]);
    check_eq({name, "_cpurst"}, 32'(rst_cnt), exp_ok ? 32'd1 : 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'(exp_ok));
    check_eq({name, "_error"}, 32'(error), 32'(!exp_ok));
    check_eq({name, "_halt"}, 32'(Halt), 32'(!exp_ok));
    check_eq({name, "_rdy"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic set_frame(input logic [7:0] b[$], input int gap);
    fb = b;
    fg.delete();
    foreach (b[i]) fg.push_back(gap);
  endtask

  task automatic gen_frame();
    int n, s;
    logic [7:0] chk;
    fb.delete();
    fg.delete();
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 1) n = $urandom_range(5, 8);
      else n = {8'($urandom_range(1, 255)), 8'($urandom)};
      fb.push_back(n[15:8]);
      fb.push_back(n[7:0]);
    end else begin
      n = $urandom_range(0, 4);
      fb.push_back(8'd0);
      fb.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) fb.push_back(8'($urandom));
      s = 0;
      foreach (fb[i]) s += int'(fb[i]);
      chk = 8'(s);
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      fb.push_back(chk);
    end
    foreach (fb[i]) begin
      if (i == 0) fg.push_back($urandom_range(0, 3));
      else if ($urandom_range(0, 19) == 0) fg.push_back($urandom_range(10, 12));
      else fg.push_back($urandom_range(0, 9));
    end
  endtask

  initial begin
    rst_cnt = 0;
    #23;
    check_eq("rst_halt", 32'(Halt), 32'd1);
    check_eq("rst_web", 32'(WEB), 32'd0);
    check_eq("rst_cpurst", 32'(cpu_rst), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_addr", 32'(ADDRB), 32'd0);
    check_eq("rst_din", 32'(DINB), 32'd0);
    check_eq("rst_rdy", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-frame reset while a write is on port B.
    set_frame('{8'h00, 8'h03, 8'h12, 8'h34}, 0);
    drive_frame();
    check_eq("mid_web_pre", 32'(WEB), 32'd1);
    check_eq("mid_wr_pre", {ADDRB, DINB}, 32'h0000_1234);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_web", 32'(WEB), 32'd0);
    check_eq("mid_halt", 32'(Halt), 32'd1);
    check_eq("mid_addr", 32'(ADDRB), 32'd0);
    check_eq("mid_din", 32'(DINB), 32'd0);
    check_eq("mid_rdy", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 0);
    run_frame("boot", 1'b0);
    check_eq("boot_model_ok", 32'(exp_ok), 32'd1);
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1}, 0);
    run_frame("badchk", 1'b1);
    set_frame('{8'h00, 8'h00, 8'h00}, 0);
    run_frame("empty_from_err", 1'b1);
    set_frame('{8'h00, 8'h00, 8'h00}, 1);
    run_frame("empty_from_idle", 1'b1);
    set_frame('{8'h00, 8'h05}, 0);
    run_frame("oversize", 1'b1);
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 9);
    run_frame("gap9", 1'b1);
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 0);
    fg[3] = 10;
    run_frame("gap10", 1'b1);

    for (int k = 0; k < 40; k++) begin
      gen_frame();
      run_frame($sformatf("rnd%0d", k), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that fills the instruction memory over its write port (port B), opposite the fetch stage's read port (port A).
- Accepts a byte stream with a valid/ready handshake, from the UART/debug link.
- Assembles big-endian 16-bit words and writes them to sequential addresses from 0.
- Holds the CPU halted while loading and pulses a CPU reset on success, so fetch restarts at PC 0.

Parameters:
ADDR_W, 16, IMEM address width (ADDRB width).
MAX_WORDS, 16'd4096, largest accepted program length in words.
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes while loading; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
rx_data  input  8  incoming byte.
rx_valid  input  1  rx_data is valid this cycle.
rx_ready  output  1  loader accepts the byte; a transfer occurs when rx_valid && rx_ready.
load_req  input  1  single-cycle request to start a reload.
ADDRB  output  ADDR_W  IMEM write address.
DINB  output  16  IMEM write data.
WEB  output  1  IMEM write enable, one cycle per word.
Halt  output  1  freezes the fetch PC while high.
cpu_rst  output  1  one-cycle CPU reset pulse after a successful load.
done  output  1  high after a successful load until the next load starts.
error  output  1  high in ERR until a new load starts.

Behaviour:
- Frame format: LEN_HI, LEN_LO, then N words sent as HI byte then LO byte, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = 8-bit sum (mod 256) of every preceding frame byte, including the length bytes.
- States: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, IDLE, ERR.
- Reset (rst_n low, asynchronous):
  - state = LEN_HI (boot load).
  - Halt = 1; WEB, cpu_rst, done, error = 0; ADDRB = 0; DINB = 0.
  - Word counter, running sum and timeout counter cleared.
  - rst_n asserted mid-load abandons the frame completely.
- rx_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK; 0 in all other states. The loader never back-pressures inside a frame.
- Every accepted byte is added to the running sum, except the CHK byte itself.
- LEN_LO accepted:
  - N == 0 -> CHECK.
  - N > MAX_WORDS -> ERR.
  - otherwise -> DATA_HI.
- DATA_HI accepted: high byte is latched; -> DATA_LO.
- DATA_LO accepted: on the next edge, DINB = {hi, lo}, ADDRB = word index, WEB = 1 for exactly one cycle.
  - Index 0 is written at ADDRB 0; indices run 0..N-1.
  - After the last word -> CHECK; otherwise -> DATA_HI.
  - Write latency is one cycle after the accepting edge.
  - Back-to-back bytes are legal; a new DATA_HI may be accepted in the same cycle WEB is high.
- CHECK accepted:
  - Byte equals the running sum -> DONE.
  - Otherwise -> ERR.
  - Words already written stay in IMEM; the program is not trusted until DONE.
- DONE (one cycle): cpu_rst = 1, Halt = 0, done = 1; -> IDLE.
- IDLE: Halt = 0, done held at 1.
  - load_req -> LEN_HI with Halt = 1 and done = 0 on the next edge.
  - Counter, sum and ADDRB are cleared at the same time.
- ERR: Halt = 1, error = 1.
  - load_req -> LEN_HI and clears error.
- load_req is ignored in all receiving states.
- Timeout: a counter increments each cycle in a receiving state with no accepted byte and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES -> ERR.
  - While in LEN_HI with no bytes yet received, the timeout is disabled, so the loader waits indefinitely for a frame.
- Widths:
  - Word counter is 16 bits; comparison to N is unsigned.
  - ADDRB is the low ADDR_W bits of the counter; MAX_WORDS ≤ 2^ADDR_W is checked by a compile-time assertion.
  - Sum is 8 bits and wraps.

Decomposition:
- Shared cpu package holds:
  - the state encoding (localparams, 3 bits);
  - the frame constants (header 2 bytes, checksum 1 byte);
  - the IMEM data width 16.
- Sub-module `byte_timeout`: the loadable idle counter, with inputs `active`, `kick` and output `expired`.
- Everything else stays in one FSM module.

Test Plan:
- Boot load: after reset, send 00 02 12 34 AB CD C0 -> WEB pulses write ADDRB 0 = 0x1234 and ADDRB 1 = 0xABCD; cpu_rst pulses once; Halt falls; done = 1.
- Bad checksum: same frame with CHK = C1 -> both words written, then ERR; error = 1, Halt stays 1, no cpu_rst pulse.
- Recovery and reload: from ERR, pulse load_req, then send 00 00 00 -> DONE with no WEB pulse; cpu_rst pulses; error clears. Repeat a reload from IDLE; Halt must rise the cycle after load_req.
- Oversize length: with MAX_WORDS = 4, send 00 05 -> ERR immediately after LEN_LO; rx_ready = 0.
- Gaps and timeout: with TIMEOUT_CYCLES = 10, rx_valid gaps of 9 cycles between bytes -> the load succeeds. A gap of 10 cycles after DATA_HI -> ERR.
- Mid-frame reset: assert rst_n low during DATA_LO -> all outputs return to reset values asynchronously (Halt = 1, WEB = 0). A fresh frame then loads from ADDRB 0.
